// File: rtl/nec_ir_pkg.sv
// Shared types and pulse-window constants for the NEC IR decoder.
// All windows are in measurement ticks (TICK_US each).
package nec_ir_pkg;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_LEAD_LO,
        ST_LEAD_HI,
        ST_BIT_LO,
        ST_BIT_HI,
        ST_RPT_LO
    } nec_state_t;

    localparam int unsigned WIDTH_W   = 11;
    localparam int unsigned BIT_CNT_W = 6;

    localparam logic [WIDTH_W-1:0] LEAD_LO_MIN = 11'd800;
    localparam logic [WIDTH_W-1:0] LEAD_LO_MAX = 11'd1000;
    localparam logic [WIDTH_W-1:0] LEAD_HI_MIN = 11'd400;
    localparam logic [WIDTH_W-1:0] LEAD_HI_MAX = 11'd500;
    localparam logic [WIDTH_W-1:0] RPT_HI_MIN  = 11'd180;
    localparam logic [WIDTH_W-1:0] RPT_HI_MAX  = 11'd270;
    localparam logic [WIDTH_W-1:0] BIT_LO_MIN  = 11'd40;
    localparam logic [WIDTH_W-1:0] BIT_LO_MAX  = 11'd72;
    localparam logic [WIDTH_W-1:0] SP0_MIN     = 11'd40;
    localparam logic [WIDTH_W-1:0] SP0_MAX     = 11'd72;
    localparam logic [WIDTH_W-1:0] SP1_MIN     = 11'd140;
    localparam logic [WIDTH_W-1:0] SP1_MAX     = 11'd200;
    localparam logic [WIDTH_W-1:0] TIMEOUT     = 11'd1100;

    function automatic logic in_win(input logic [WIDTH_W-1:0] w,
                                    input logic [WIDTH_W-1:0] lo,
                                    input logic [WIDTH_W-1:0] hi);
        return (w >= lo) && (w <= hi);
    endfunction

endpackage

// File: rtl/ir_edge_sync.sv
// Two-flop synchronizer for the IR pin with registered fall/rise strobes.
// Resets to the idle-high line level so no edge is reported on release.
module ir_edge_sync (
    input  logic clk,
    input  logic res,
    input  logic ir,
    output logic fall,
    output logic rise
);

    logic s1, s2, prev;

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            s1   <= 1'b1;
            s2   <= 1'b1;
            prev <= 1'b1;
            fall <= 1'b0;
            rise <= 1'b0;
        end else begin
            s1   <= ir;
            s2   <= s1;
            prev <= s2;
            fall <= prev & ~s2;
            rise <= ~prev & s2;
        end
    end

endmodule

// File: rtl/nec_ir_decoder.sv
// NEC IR frame decoder: pulse-width FSM producing a 32-bit code word.
// Define NEC_CHECK_EN to reject frames whose inverted address/command bytes mismatch.
module nec_ir_decoder
    import nec_ir_pkg::*;
#(
    parameter int unsigned CLK_HZ  = 50_000_000,
    parameter int unsigned TICK_US = 10
) (
    input  logic        clk,
    input  logic        res,
    input  logic        ir,
    output logic [31:0] code,
    output logic        data_valid,
    output logic        repeat_pulse,
    output logic        error
);

    localparam int unsigned PRESCALE = CLK_HZ / 1_000_000 * TICK_US;
    localparam int unsigned PS_W     = (PRESCALE > 1) ? $clog2(PRESCALE) : 1;

    logic                 ir_fall, ir_rise, edge_any, tick;
    logic [PS_W-1:0]      ps_cnt;
    logic [WIDTH_W-1:0]   width;
    nec_state_t           state;
    logic [BIT_CNT_W-1:0] bit_cnt;
    logic [31:0]          sr, sr_next;
    logic                 has_frame, space_one, space_ok, frame_ok;

    ir_edge_sync u_sync (
        .clk  (clk),
        .res  (res),
        .ir   (ir),
        .fall (ir_fall),
        .rise (ir_rise)
    );

    assign edge_any = ir_fall | ir_rise;
    // An edge wins over a coincident tick: the tick is simply dropped.
    assign tick     = !edge_any && (ps_cnt == PS_W'(PRESCALE - 1));

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            ps_cnt <= '0;
        else if (edge_any || tick)
            ps_cnt <= '0;
        else
            ps_cnt <= ps_cnt + PS_W'(1);
    end

    always_ff @(posedge clk or negedge res) begin
        if (!res)
            width <= '0;
        else if (edge_any)
            width <= '0;
        else if (tick && width != '1)
            width <= width + WIDTH_W'(1);
    end

    assign space_one = in_win(width, SP1_MIN, SP1_MAX);
    assign space_ok  = space_one || in_win(width, SP0_MIN, SP0_MAX);
    assign sr_next   = {space_one, sr[31:1]};

`ifdef NEC_CHECK_EN
    assign frame_ok = (sr_next[15:8] == ~sr_next[7:0]) &&
                      (sr_next[31:24] == ~sr_next[23:16]);
`else
    assign frame_ok = 1'b1;
`endif

    always_ff @(posedge clk or negedge res) begin
        if (!res) begin
            state        <= ST_IDLE;
            bit_cnt      <= '0;
            sr           <= '0;
            code         <= '0;
            has_frame    <= 1'b0;
            data_valid   <= 1'b0;
            repeat_pulse <= 1'b0;
            error        <= 1'b0;
        end else begin
            data_valid   <= 1'b0;
            repeat_pulse <= 1'b0;
            error        <= 1'b0;
            if (state != ST_IDLE && !edge_any && width > TIMEOUT) begin
                error <= 1'b1;
                state <= ST_IDLE;
            end else begin
                case (state)
                    ST_IDLE: if (ir_fall) state <= ST_LEAD_LO;
                    ST_LEAD_LO: if (ir_rise) begin
                        if (in_win(width, LEAD_LO_MIN, LEAD_LO_MAX)) begin
                            state <= ST_LEAD_HI;
                        end else begin
                            error <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    ST_LEAD_HI: if (ir_fall) begin
                        if (in_win(width, LEAD_HI_MIN, LEAD_HI_MAX)) begin
                            bit_cnt <= '0;
                            state   <= ST_BIT_LO;
                        end else if (in_win(width, RPT_HI_MIN, RPT_HI_MAX)) begin
                            state <= ST_RPT_LO;
                        end else begin
                            error <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    ST_BIT_LO: if (ir_rise) begin
                        if (in_win(width, BIT_LO_MIN, BIT_LO_MAX)) begin
                            state <= ST_BIT_HI;
                        end else begin
                            error <= 1'b1;
                            state <= ST_IDLE;
                        end
                    end
                    ST_BIT_HI: if (ir_fall) begin
                        if (!space_ok) begin
                            error <= 1'b1;
                            state <= ST_IDLE;
                        end else begin
                            sr      <= sr_next;
                            bit_cnt <= bit_cnt + BIT_CNT_W'(1);
                            // Frame completes on bit 32's space; the stop burst is ignored in IDLE.
                            if (bit_cnt == BIT_CNT_W'(31)) begin
                                state <= ST_IDLE;
                                if (frame_ok) begin
                                    code       <= sr_next;
                                    data_valid <= 1'b1;
                                    has_frame  <= 1'b1;
                                end else begin
                                    error <= 1'b1;
                                end
                            end else begin
                                state <= ST_BIT_LO;
                            end
                        end
                    end
                    ST_RPT_LO: if (ir_rise) begin
                        state <= ST_IDLE;
                        if (!in_win(width, BIT_LO_MIN, BIT_LO_MAX))
                            error <= 1'b1;
                        else if (has_frame)
                            repeat_pulse <= 1'b1;
                    end
                    default: state <= ST_IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_nec_ir_decoder.sv
// Self-checking bench for nec_ir_decoder using a frame-level scoreboard.
// Runs with 1 clock per tick so whole NEC frames fit in a short simulation.
module tb_nec_ir_decoder;

    logic        clk = 1'b0;
    logic        res = 1'b0;
    logic        ir  = 1'b1;
    logic [31:0] code;
    logic        data_valid, repeat_pulse, error;

    int unsigned checks = 0, errors = 0;
    int unsigned dv_cnt = 0, rpt_cnt = 0, err_cnt = 0, onehot_viol = 0;
    int unsigned exp_dv = 0, exp_rpt = 0, exp_err = 0;
    logic [31:0] exp_code = '0;
    bit          exp_has = 1'b0;

    always #5 clk = ~clk;

    nec_ir_decoder #(.CLK_HZ(1_000_000), .TICK_US(1)) dut (
        .clk          (clk),
        .res          (res),
        .ir           (ir),
        .code         (code),
        .data_valid   (data_valid),
        .repeat_pulse (repeat_pulse),
        .error        (error)
    );

    always @(negedge clk) begin
        if (data_valid)   dv_cnt++;
        if (repeat_pulse) rpt_cnt++;
        if (error)        err_cnt++;
        if (int'(data_valid) + int'(repeat_pulse) + int'(error) > 1) onehot_viol++;
    end

    function automatic int unsigned pick(int unsigned lo, int unsigned hi,
                                         int unsigned nom, bit rnd);
        return rnd ? $urandom_range(hi - 3, lo + 3) : nom;
    endfunction

    // Hold the line for a given number of ticks (1 tick = 1 clock here).
    task automatic hold(logic lvl, int unsigned ticks);
        ir = lvl;
        repeat (ticks + 1) @(posedge clk);
    endtask

    task automatic send_frame(logic [31:0] w, int unsigned nbits, bit rnd);
        hold(1'b0, pick(800, 1000, 900, rnd));
        hold(1'b1, pick(400, 500, 450, rnd));
        for (int i = 0; i < int'(nbits); i++) begin
            hold(1'b0, pick(40, 72, 56, rnd));
            if (w[i]) hold(1'b1, pick(140, 200, 169, rnd));
            else      hold(1'b1, pick(40, 72, 56, rnd));
        end
        if (nbits == 32) begin
            hold(1'b0, 56);
            hold(1'b1, 200);
        end
    endtask

    task automatic send_repeat();
        hold(1'b0, 900);
        hold(1'b1, 225);
        hold(1'b0, 56);
        hold(1'b1, 200);
    endtask

    // Reference model: what one complete frame should do to the outputs.
    task automatic model_frame(logic [31:0] w);
        logic [7:0] a, na, c, nc;
        bit ok;
        {nc, c, na, a} = w;
`ifdef NEC_CHECK_EN
        ok = (na == ~a) && (nc == ~c);
`else
        ok = 1'b1;
`endif
        if (ok) begin
            exp_dv++;
            exp_code = w;
            exp_has  = 1'b1;
        end else begin
            exp_err++;
        end
    endtask

    task automatic model_repeat();
        if (exp_has) exp_rpt++;
    endtask

    task automatic do_reset();
        res = 1'b0;
        repeat (3) @(posedge clk);
        #1;
        exp_code = '0;
        exp_has  = 1'b0;
        res = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_reset();
        res = 1'b0;
        ir  = 1'b1;
        repeat (4) @(posedge clk);
        @(negedge clk);
        checks++;
        if (code !== 32'h0) begin errors++; $display("FAIL reset_code: got %h want 00000000", code); end
        checks++;
        if ({data_valid, repeat_pulse, error} !== 3'b000) begin
            errors++; $display("FAIL reset_pulses: got %b want 000", {data_valid, repeat_pulse, error});
        end
        res = 1'b1;
        repeat (5) @(posedge clk);
    endtask

    task automatic test_nominal_frame();
        logic [31:0] w;
        w = {~8'h45, 8'h45, ~8'h00, 8'h00};
        send_frame(w, 32, 1'b0);
        model_frame(w);
        checks++;
        if (dv_cnt !== exp_dv) begin errors++; $display("FAIL nominal_dv: got %0d want %0d", dv_cnt, exp_dv); end
        checks++;
        if (code !== 32'hBA45FF00) begin errors++; $display("FAIL nominal_code: got %h want BA45FF00", code); end
    endtask

    task automatic test_repeat();
        send_repeat();
        model_repeat();
        checks++;
        if (rpt_cnt !== exp_rpt) begin errors++; $display("FAIL repeat_cnt: got %0d want %0d", rpt_cnt, exp_rpt); end
        checks++;
        if (code !== exp_code) begin errors++; $display("FAIL repeat_code: got %h want %h", code, exp_code); end
    endtask

    task automatic test_repeat_after_reset();
        do_reset();
        send_repeat();
        model_repeat();
        checks++;
        if ({rpt_cnt, err_cnt, dv_cnt} !== {exp_rpt, exp_err, exp_dv}) begin
            errors++;
            $display("FAIL rpt_after_reset: got rpt=%0d err=%0d dv=%0d want rpt=%0d err=%0d dv=%0d",
                     rpt_cnt, err_cnt, dv_cnt, exp_rpt, exp_err, exp_dv);
        end
    endtask

    task automatic test_bad_leader();
        logic [31:0] w;
        hold(1'b0, 500);
        hold(1'b1, 300);
        exp_err++;
        checks++;
        if (err_cnt !== exp_err) begin errors++; $display("FAIL bad_leader_err: got %0d want %0d", err_cnt, exp_err); end
        w = {~8'h16, 8'h16, ~8'h04, 8'h04};
        send_frame(w, 32, 1'b0);
        model_frame(w);
        checks++;
        if (dv_cnt !== exp_dv || code !== exp_code) begin
            errors++; $display("FAIL bad_leader_recover: got dv=%0d code=%h want dv=%0d code=%h",
                               dv_cnt, code, exp_dv, exp_code);
        end
    endtask

    task automatic test_corrupt_cmd();
        logic [31:0] w;
        w = 32'h0045FF00;
        send_frame(w, 32, 1'b0);
        model_frame(w);
        checks++;
        if (dv_cnt !== exp_dv || err_cnt !== exp_err) begin
            errors++; $display("FAIL corrupt_pulses: got dv=%0d err=%0d want dv=%0d err=%0d",
                               dv_cnt, err_cnt, exp_dv, exp_err);
        end
        checks++;
        if (code !== exp_code) begin errors++; $display("FAIL corrupt_code: got %h want %h", code, exp_code); end
    endtask

    task automatic test_timeout();
        hold(1'b0, 900);
        hold(1'b1, 1500);
        exp_err++;
        checks++;
        if (err_cnt !== exp_err) begin errors++; $display("FAIL timeout_err: got %0d want %0d", err_cnt, exp_err); end
    endtask

    task automatic test_reset_mid_frame();
        logic [31:0] w;
        w = {~8'hA7, 8'hA7, ~8'h5C, 8'h5C};
        send_frame(w, 16, 1'b0);
        res = 1'b0;
        #1;
        exp_code = '0;
        exp_has  = 1'b0;
        checks++;
        if (code !== 32'h0) begin errors++; $display("FAIL midreset_code: got %h want 00000000", code); end
        ir = 1'b1;
        repeat (3) @(posedge clk);
        res = 1'b1;
        repeat (5) @(posedge clk);
        send_frame(w, 32, 1'b0);
        model_frame(w);
        checks++;
        if (dv_cnt !== exp_dv || code !== exp_code) begin
            errors++; $display("FAIL midreset_frame: got dv=%0d code=%h want dv=%0d code=%h",
                               dv_cnt, code, exp_dv, exp_code);
        end
    endtask

    task automatic test_random_frames();
        logic [31:0] w;
        logic [7:0]  a, c;
        for (int n = 0; n < 3; n++) begin
            a = 8'($urandom);
            c = 8'($urandom);
            if (n == 1) w = $urandom;
            else        w = {~c, c, ~a, a};
            send_frame(w, 32, 1'b1);
            model_frame(w);
            checks++;
            if (dv_cnt !== exp_dv || err_cnt !== exp_err || code !== exp_code) begin
                errors++;
                $display("FAIL random_frame%0d: got dv=%0d err=%0d code=%h want dv=%0d err=%0d code=%h",
                         n, dv_cnt, err_cnt, code, exp_dv, exp_err, exp_code);
            end
        end
        send_repeat();
        model_repeat();
        checks++;
        if (rpt_cnt !== exp_rpt) begin errors++; $display("FAIL random_repeat: got %0d want %0d", rpt_cnt, exp_rpt); end
    endtask

    initial begin
        test_reset();
        test_nominal_frame();
        test_repeat();
        test_repeat_after_reset();
        test_bad_leader();
        test_corrupt_cmd();
        test_timeout();
        test_reset_mid_frame();
        test_random_frames();
        checks++;
        if (onehot_viol !== 0) begin errors++; $display("FAIL onehot_pulses: got %0d overlaps want 0", onehot_viol); end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/nec_ir_decoder.md
# nec_ir_decoder

Decodes the NEC infrared protocol from the demodulated receiver pin into a 32-bit frame word with a one-cycle valid strobe. Sits between the board `ir` pin and the top level's `regIRHigh`/`regIRLow` capture registers, which read `code[31:16]` and `code[15:0]` on `data_valid`. Also flags repeat codes and malformed frames so firmware can poll them through the bus.

## Interface
- `CLK_HZ`, 50_000_000: system clock frequency; sets the prescaler.
- `TICK_US`, 10: measurement tick period in µs. All pulse windows are expressed in ticks.
- `clk` input 1: system clock. All logic is in this single domain.
- `res` input 1: reset, asynchronous, active-low. Clears all state.
- `ir` input 1: raw receiver output. Idle high; low means carrier burst. Asynchronous to `clk`.
- `code` output 32: last accepted frame. Reset value 0.
- `data_valid` output 1: one-cycle pulse when `code` updates. Reset value 0.
- `repeat_pulse` output 1: one-cycle pulse on a valid repeat code. Reset value 0.
- `error` output 1: one-cycle pulse on an aborted or malformed frame. Reset value 0.

## Operation
- Input path: 2-flop synchronizer on `ir`, then a registered previous value for edge detection. A fall is a burst start; a rise is a burst end.
- Prescaler: counts `CLK_HZ/1_000_000*TICK_US` clocks per tick (500 at the defaults). It clears on every detected edge.
- Width counter: 11-bit tick count, cleared on every edge, saturating at 2047.
- Windows, in ticks at the 10 µs default:
  - leader burst 800..1000
  - leader space 400..500 means data; 180..270 means repeat
  - bit burst 40..72
  - space 40..72 means 0; 140..200 means 1
- Timeout: width > 1100 in any non-IDLE state gives `error` and a return to IDLE.
- FSM states: IDLE, LEAD_LO, LEAD_HI, BIT_LO, BIT_HI, RPT_LO.
  - IDLE: fall → LEAD_LO.
  - LEAD_LO: rise, width in leader window → LEAD_HI; else `error` → IDLE.
  - LEAD_HI: fall with data space → BIT_LO with bit count 0; repeat space → RPT_LO; else `error` → IDLE.
  - BIT_LO: rise, width in bit window → BIT_HI; else `error` → IDLE.
  - BIT_HI: fall classifies the space as a 0 or 1 bit; out of window gives `error` → IDLE.
    - Bit shifts into a 32-bit shift register from the MSB side (`sr <= {bit, sr[31:1]}`), so the first received bit lands in bit 0.
    - Bit count increments. At 32 the frame is checked, then → IDLE; the stop burst is not awaited. Otherwise → BIT_LO.
  - RPT_LO: rise, width in bit window, and a frame accepted since reset → `repeat_pulse`, IDLE. In window but no prior frame → IDLE silently. Out of window → `error`, IDLE.
- Frame layout: `code[7:0]`=address, `[15:8]`=~address, `[23:16]`=command, `[31:24]`=~command.
- Acceptance: `code <= sr` and `data_valid` pulse. On a rejected frame (see Configuration), `code` holds its old value and `error` pulses.
- At most one of `data_valid`, `repeat_pulse`, `error` is high in any cycle.

## Timing
- Edge detection latency: 3 clocks from a raw `ir` transition (2 sync + 1 edge register).
- `data_valid`/`code` are registered 1 clock after the edge that ends bit 32's space. That is 4 clocks after the raw falling edge.
- Edge and tick in the same cycle: the edge wins; the width is sampled before the clear, and the tick is discarded.
- Glitches shorter than 2 clocks may be lost in the synchronizer. No further filtering is applied.
- Reset asserted mid-frame: state, counters, shift register, `code` and the prior-frame flag all clear immediately. The first frame after release needs a full leader.

## Configuration
- `NEC_CHECK_EN` defined: accept a frame only if `code[15:8]==~code[7:0]` and `code[31:24]==~code[23:16]`. Otherwise pulse `error`.
- `NEC_CHECK_EN` undefined: accept any 32-bit frame, including extended-address remotes. The comparators are not built.

## Structure
- Package `nec_ir_pkg` holds:
  - the state enum
  - tick window constants (min/max per pulse class)
  - the timeout constant
  - bit-count width
- One sub-module, `ir_edge_sync`: 2-flop synchronizer plus fall/rise strobes, async active-low reset to idle-high.

## Test plan
- Frame addr 0x00, cmd 0x45 at nominal widths → `data_valid` one cycle, `code`=0xBA45FF00.
- Same frame, then a repeat (9 ms burst / 2.25 ms space / 560 µs burst) → one `repeat_pulse`, `code` unchanged.
- Repeat sequence straight after reset → no `repeat_pulse`, no `error`, no `data_valid`.
- Leader burst of 5 ms → `error` pulse, IDLE; a following valid frame still decodes.
- Frame with the ~command byte corrupted (0x00) → `error` with `NEC_CHECK_EN`; `data_valid` with `code`=0x0045FF00 without it.
- `res` asserted after bit 15, then a full valid frame → `code` reads 0 until the new frame sets it; exactly one `data_valid`.
